// File: rtl/forward_scoreboard_if.sv
// Issue/flush/operand-lookup bundle between the issue stage and forward_scoreboard.
// The master drives issue and source fields; the slave returns selects, stall and status.
interface forward_scoreboard_if #(
   parameter int AW   = 5,
   parameter int NSRC = 2,
   parameter int SW   = 2
);
   logic                 issue_valid_i;
   logic [AW-1:0]        issue_rd_i;
   logic                 issue_wr_i;
   logic [SW-1:0]        issue_lat_i;
   logic                 flush_i;
   logic [NSRC-1:0]      src_valid_i;
   logic [NSRC*AW-1:0]   src_reg_i;
   logic [NSRC*SW-1:0]   fwd_sel_o;
   logic                 stall_o;
   logic                 busy_o;
   logic [15:0]          stall_cnt_o;

   modport master (
      output issue_valid_i, issue_rd_i, issue_wr_i, issue_lat_i, flush_i,
      output src_valid_i, src_reg_i,
      input  fwd_sel_o, stall_o, busy_o, stall_cnt_o
   );

   modport slave (
      input  issue_valid_i, issue_rd_i, issue_wr_i, issue_lat_i, flush_i,
      input  src_valid_i, src_reg_i,
      output fwd_sel_o, stall_o, busy_o, stall_cnt_o
   );
endinterface

// File: rtl/forward_scoreboard.sv
// Tracks in-flight producers through NSTAGE post-issue stages and picks, per source
// operand, the youngest matching producer as forward source or raises a stall.
module forward_scoreboard #(
   parameter int AW     = 5,
   parameter int NSTAGE = 3,
   parameter int NSRC   = 2,
   parameter int SW     = 2
) (
   input  logic                clk_i,
   input  logic                rst_i,
   forward_scoreboard_if.slave sb
);

   logic [NSTAGE:1] v_q, v_d;
   logic [NSTAGE:1] wr_q, wr_d;
   logic [AW-1:0]   rd_q  [1:NSTAGE];
   logic [AW-1:0]   rd_d  [1:NSTAGE];
   logic [SW-1:0]   rem_q [1:NSTAGE];
   logic [SW-1:0]   rem_d [1:NSTAGE];
   logic [15:0]     stall_cnt_q, stall_cnt_d;

   logic [NSRC*SW-1:0] fwd_sel;
   logic [NSRC-1:0]    stall_req;
   logic               stall;
   logic [SW-1:0]      lat_c;

   always_comb begin
      lat_c = sb.issue_lat_i;
      if (lat_c == '0) begin
         lat_c = SW'(1);
      end else if (int'(lat_c) > NSTAGE) begin
         lat_c = SW'(NSTAGE);
      end
   end

   // Walk oldest to youngest so the lowest-indexed match overwrites older ones.
   always_comb begin
      fwd_sel   = '0;
      stall_req = '0;
      for (int j = 0; j < NSRC; j++) begin
         for (int s = NSTAGE; s >= 1; s--) begin
            if (v_q[s] && wr_q[s] && (rd_q[s] != '0) && sb.src_valid_i[j] &&
                (rd_q[s] == sb.src_reg_i[j*AW +: AW])) begin
               fwd_sel[j*SW +: SW] = (rem_q[s] == '0) ? SW'(s) : '0;
               stall_req[j]        = (rem_q[s] != '0);
            end
         end
      end
      stall = |stall_req;
   end

   always_comb begin
      v_d      = '0;
      wr_d     = '0;
      v_d[1]   = sb.issue_valid_i && !stall && !sb.flush_i;
      rd_d[1]  = sb.issue_rd_i;
      wr_d[1]  = sb.issue_wr_i;
      rem_d[1] = lat_c - SW'(1);
      // A flush kills the stage-1 entry on its way into stage 2; older stages keep moving.
      for (int s = 2; s <= NSTAGE; s++) begin
         v_d[s]   = v_q[s-1] && !((s == 2) && sb.flush_i);
         rd_d[s]  = rd_q[s-1];
         wr_d[s]  = wr_q[s-1];
         rem_d[s] = (rem_q[s-1] == '0) ? '0 : rem_q[s-1] - SW'(1);
      end
      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         v_q         <= '0;
         wr_q        <= '0;
         stall_cnt_q <= '0;
         for (int s = 1; s <= NSTAGE; s++) begin
            rd_q[s]  <= '0;
            rem_q[s] <= '0;
         end
      end else begin
         v_q         <= v_d;
         wr_q        <= wr_d;
         stall_cnt_q <= stall_cnt_d;
         for (int s = 1; s <= NSTAGE; s++) begin
            rd_q[s]  <= rd_d[s];
            rem_q[s] <= rem_d[s];
         end
      end
   end

   assign sb.fwd_sel_o   = fwd_sel;
   assign sb.stall_o     = stall;
   assign sb.busy_o      = |v_q;
   assign sb.stall_cnt_o = stall_cnt_q;

endmodule

// File: doc/forward_scoreboard.md
FORWARD_SCOREBOARD -- requirements
Module: forward_scoreboard

Interface
REQ-001 Parameter AW, default 5, register-address width.
REQ-002 Parameter NSTAGE, default 3, number of tracked post-issue pipeline stages (2..7).
REQ-003 Parameter NSRC, default 2, number of source operands checked per cycle (1..4).
REQ-004 Parameter SW, default 2, select width; SHALL satisfy 2^SW > NSTAGE.
REQ-005 clk_i  input  1  single clock; all state updates on rising edge.
REQ-006 rst_i  input  1  asynchronous, active-low reset.
REQ-007 issue_valid_i  input  1  an instruction enters stage 1 at this edge.
REQ-008 issue_rd_i  input  AW  destination register of the issuing instruction.
REQ-009 issue_wr_i  input  1  issuing instruction writes issue_rd_i.
REQ-010 issue_lat_i  input  SW  stages until result is forwardable (1 = ALU, 2 = load, ...).
REQ-011 flush_i  input  1  squash the issuing instruction and the stage-1 entry.
REQ-012 src_valid_i  input  NSRC  per-operand "operand is used".
REQ-013 src_reg_i  input  NSRC*AW  per-operand source register, operand j at bits [j*AW +: AW].
REQ-014 fwd_sel_o  output  NSRC*SW  per-operand select: 0 = register file, s = stage s result.
REQ-015 stall_o  output  1  a used operand depends on a not-yet-ready result.
REQ-016 busy_o  output  1  at least one stage entry is valid.
REQ-017 stall_cnt_o  output  16  saturating count of stalled cycles.

Function
REQ-018 Each stage s (1..NSTAGE) SHALL hold v, rd[AW], wr, rem[SW].
REQ-019 Every edge: stage s+1 loads stage s; rem decrements, saturating at 0.
REQ-020 Stage 1 SHALL load {1, issue_rd_i, issue_wr_i, lat-1} when issue_valid_i=1, stall_o=0 and flush_i=0; otherwise it takes a bubble (v=0).
REQ-021 lat = issue_lat_i, with 0 treated as 1 and values above NSTAGE clamped to NSTAGE.
REQ-022 flush_i=1: stage 1 SHALL NOT advance into stage 2 (stage 2 becomes a bubble); stages 2..NSTAGE shift normally.
REQ-023 An entry matches operand j when v=1, wr=1, rd!=0, rd==src_reg_j and src_valid_i[j]=1.
REQ-024 Only the lowest-indexed matching stage (youngest producer) SHALL be considered for operand j.
REQ-025 If that entry has rem==0, fwd_sel_o[j] SHALL equal its stage index; otherwise it is 0 and the operand requests a stall.
REQ-026 No match, src_reg_j==0, or src_valid_i[j]=0: fwd_sel_o[j] SHALL be 0 with no stall request.
REQ-027 stall_o SHALL be the OR of all per-operand stall requests.
REQ-028 fwd_sel_o and stall_o SHALL be combinational from current stage state and src inputs only, never from issue_* inputs.
REQ-029 stall_o=1 SHALL NOT freeze stages 2..NSTAGE; the bubble inserted into stage 1 lets the producer advance.
REQ-030 busy_o = OR of all stage v bits.
REQ-031 stall_cnt_o SHALL increment at each edge where stall_o=1, saturating at 16'hFFFF; it is not cleared by flush_i.
REQ-032 Simultaneous issue_valid_i and flush_i: flush wins, and no entry is created.

Reset
REQ-033 rst_i=0 SHALL asynchronously clear every v, rd, wr, rem and stall_cnt_o to 0.
REQ-034 During and immediately after reset: fwd_sel_o=0, stall_o=0, busy_o=0.
REQ-035 Reset asserted mid-stall SHALL drop stall_o the same cycle, and the next issue loads normally.

Verification
REQ-036 Issue rd=3, wr=1, lat=1; next cycle src0=3 -> fwd_sel0=1, stall_o=0; following cycle -> fwd_sel0=2.
REQ-037 Issue load rd=5, lat=2; next cycle src1=5 -> stall_o=1, fwd_sel1=0, stage 1 bubble; next cycle -> fwd_sel1=2, stall_o=0, stall_cnt_o=1.
REQ-038 Issue rd=4, then rd=4 again (both lat=1); src0=4 -> fwd_sel0=1 (youngest wins); src_reg=0 with a matching rd=0 write -> sel 0.
REQ-039 Issue rd=7 together with flush_i=1 -> busy_o stays 0; src0=7 next cycle -> sel 0. Flush while stage 1 holds rd=6 -> stage 2 empty next cycle.
REQ-040 Force stall_o continuously from stall_cnt_o=16'hFFFE -> reads 16'hFFFF and holds; assert rst_i=0 -> all outputs 0 without a clock edge.
